// File: rtl/clock_pkg.sv
// Shared definitions for the clock time controller.
// Holds the controller state encoding, the minute/second terminal counts,
// the counter width and the zero-hour management helpers. The helpers are
// used on the switch input (display form to internal form) and on the
// display output (internal form to display form).
package clock_pkg;

  localparam int HRS_W = 7;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HRS = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  localparam logic [HRS_W-1:0] MIN_TC = 7'd59;
  localparam logic [HRS_W-1:0] SEC_TC = 7'd59;

  // Internal hour 0 is shown as tc+1 (e.g. 12) when management is on.
  function automatic logic [HRS_W-1:0] hour_to_display(
    input logic [HRS_W-1:0] hrs,
    input logic [HRS_W-1:0] tc,
    input logic             manage
  );
    if (manage && hrs == '0) return tc + 7'd1;
    return hrs;
  endfunction

  // Switch hours arrive in display form: tc+1 means internal 0, and a
  // switch value of 0 maps to tc+1, which is out of range and rejected.
  function automatic logic [HRS_W-1:0] hour_from_display(
    input logic [HRS_W-1:0] disp,
    input logic [HRS_W-1:0] tc,
    input logic             manage
  );
    if (manage && disp == tc + 7'd1) return '0;
    if (manage && disp == '0) return tc + 7'd1;
    return disp;
  endfunction

endpackage

// File: rtl/clock_time_ctrl_edge_pulse.sv
// edge_pulse: converts a debounced button level into a single-cycle press
// pulse on its rising edge.
// Ports:
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset
//   level_i  debounced button level
//   pulse_o  one-cycle pulse, high in the cycle the level is first seen high
module edge_pulse (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;
  logic armed_q;

  // prev_q remembers last cycle's level for edge detection. armed_q only
  // sets once the level has been seen low after reset, so a button held
  // through reset deassertion must be released and pressed again.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= level_i;
      armed_q <= armed_q | ~level_i;
    end
  end

  assign pulse_o = level_i & ~prev_q & armed_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: sequencing controller for the hours/minutes/seconds
// counters. Runs time from a 1 Hz tick, walks RUN -> SET_HRS -> SET_MIN ->
// RUN on mode presses, increments the edited field on inc presses, and
// loads time from the switch bank on load presses.
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   tick_i                1 Hz single-cycle enable
//   mode_btn_i            debounced mode button level
//   inc_btn_i             debounced increment button level
//   load_i                debounced load-from-switches button level
//   sw_hrs_i, sw_min_i    switch hours (display form) and minutes
//   hrs_o, min_o, sec_o   registered display time (hours managed)
//   pm_o                  PM flag, 12-hour builds only
//   state_o               00 RUN, 01 SET_HRS, 10 SET_MIN
//   blink_o               field under edit: bit1 hours, bit0 minutes
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int cntr_tc_p          = 11,
  parameter bit manage_zero_hour_p = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tick_i,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  input  logic       load_i,
  input  logic [6:0] sw_hrs_i,
  input  logic [6:0] sw_min_i,
  output logic [6:0] hrs_o,
  output logic [6:0] min_o,
  output logic [6:0] sec_o,
  output logic       pm_o,
  output logic [1:0] state_o,
  output logic [1:0] blink_o
);

  localparam logic [HRS_W-1:0] HRS_TC = 7'(cntr_tc_p);
  localparam logic             IS_12H = (cntr_tc_p == 11);
  localparam logic             MANAGE = manage_zero_hour_p;

  logic mode_pulse;
  logic inc_pulse;
  logic load_pulse;

  edge_pulse u_mode_edge (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .level_i (mode_btn_i),
    .pulse_o (mode_pulse)
  );

  edge_pulse u_inc_edge (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .level_i (inc_btn_i),
    .pulse_o (inc_pulse)
  );

  edge_pulse u_load_edge (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .level_i (load_i),
    .pulse_o (load_pulse)
  );

  state_t           state_q, state_nxt;
  logic [HRS_W-1:0] hrs_q, hrs_nxt;
  logic [HRS_W-1:0] min_q, min_nxt;
  logic [HRS_W-1:0] sec_q, sec_nxt;
  logic             pm_q, pm_nxt;
  logic [HRS_W-1:0] hrs_disp_q;
  logic [1:0]       blink_q, blink_nxt;
  logic [HRS_W-1:0] sw_hrs_int;
  logic             load_ok;

  // Switch validation: the converted hour must be in range and the minutes
  // must be a legal minute. A displayed 0 hour is never valid when managed.
  always_comb begin
    sw_hrs_int = hour_from_display(sw_hrs_i, HRS_TC, MANAGE);
    load_ok    = (sw_hrs_int <= HRS_TC) && (sw_min_i <= MIN_TC) &&
                 !(MANAGE && sw_hrs_i == '0);
  end

  // Next-state logic. Only the highest-priority event in a cycle acts
  // (load > mode > inc > tick); the rest are dropped. A rejected load still
  // consumes the cycle.
  always_comb begin
    state_nxt = state_q;
    hrs_nxt   = hrs_q;
    min_nxt   = min_q;
    sec_nxt   = sec_q;
    pm_nxt    = pm_q;
    blink_nxt = 2'b00;

    if (load_pulse) begin
      if (load_ok) begin
        hrs_nxt   = sw_hrs_int;
        min_nxt   = sw_min_i;
        sec_nxt   = '0;
        state_nxt = ST_RUN;
      end
    end else if (mode_pulse) begin
      case (state_q)
        ST_RUN:     state_nxt = ST_SET_HRS;
        ST_SET_HRS: state_nxt = ST_SET_MIN;
        ST_SET_MIN: begin
          state_nxt = ST_RUN;
          sec_nxt   = '0;
        end
        default:    state_nxt = ST_RUN;
      endcase
    end else if (inc_pulse) begin
      case (state_q)
        ST_SET_HRS: begin
          if (hrs_q >= HRS_TC) begin
            hrs_nxt = '0;
            if (IS_12H) pm_nxt = ~pm_q;
          end else begin
            hrs_nxt = hrs_q + 7'd1;
          end
        end
        ST_SET_MIN: min_nxt = (min_q >= MIN_TC) ? '0 : min_q + 7'd1;
        default:    ;
      endcase
    end else if (tick_i && state_q == ST_RUN) begin
      // Full seconds -> minutes -> hours ripple resolves in one cycle.
      if (sec_q >= SEC_TC) begin
        sec_nxt = '0;
        if (min_q >= MIN_TC) begin
          min_nxt = '0;
          if (hrs_q >= HRS_TC) begin
            hrs_nxt = '0;
            if (IS_12H) pm_nxt = ~pm_q;
          end else begin
            hrs_nxt = hrs_q + 7'd1;
          end
        end else begin
          min_nxt = min_q + 7'd1;
        end
      end else begin
        sec_nxt = sec_q + 7'd1;
      end
    end

    case (state_nxt)
      ST_SET_HRS: blink_nxt = 2'b10;
      ST_SET_MIN: blink_nxt = 2'b01;
      default:    blink_nxt = 2'b00;
    endcase
  end

  // State and counter registers. The display hour and blink mask are
  // registered from next-state values so every output changes in the same
  // cycle as the counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RUN;
      hrs_q      <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      pm_q       <= 1'b0;
      hrs_disp_q <= hour_to_display('0, HRS_TC, MANAGE);
      blink_q    <= 2'b00;
    end else begin
      state_q    <= state_nxt;
      hrs_q      <= hrs_nxt;
      min_q      <= min_nxt;
      sec_q      <= sec_nxt;
      pm_q       <= pm_nxt;
      hrs_disp_q <= hour_to_display(hrs_nxt, HRS_TC, MANAGE);
      blink_q    <= blink_nxt;
    end
  end

  assign hrs_o   = hrs_disp_q;
  assign min_o   = min_q;
  assign sec_o   = sec_q;
  assign pm_o    = pm_q;
  assign state_o = state_q;
  assign blink_o = blink_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Testbench for clock_time_ctrl in its 12-hour managed build. Stimulus
// pushes expected output snapshots into a queue; a monitor pops and
// compares them on the falling clock edge.
module tb_clock_time_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       tick_i;
  logic       mode_btn_i;
  logic       inc_btn_i;
  logic       load_i;
  logic [6:0] sw_hrs_i;
  logic [6:0] sw_min_i;
  logic [6:0] hrs_o;
  logic [6:0] min_o;
  logic [6:0] sec_o;
  logic       pm_o;
  logic [1:0] state_o;
  logic [1:0] blink_o;

  typedef struct {
    string      name;
    logic [6:0] hrs;
    logic [6:0] min;
    logic [6:0] sec;
    logic       pm;
    logic [1:0] state;
    logic [1:0] blink;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  clock_time_ctrl #(
    .cntr_tc_p          (11),
    .manage_zero_hour_p (1'b1)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .tick_i     (tick_i),
    .mode_btn_i (mode_btn_i),
    .inc_btn_i  (inc_btn_i),
    .load_i     (load_i),
    .sw_hrs_i   (sw_hrs_i),
    .sw_min_i   (sw_min_i),
    .hrs_o      (hrs_o),
    .min_o      (min_o),
    .sec_o      (sec_o),
    .pm_o       (pm_o),
    .state_o    (state_o),
    .blink_o    (blink_o)
  );

  // Free-running 100 MHz-style clock.
  always #5 clk_i = ~clk_i;

  // Hard stop in case something stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareField(input string nm, input string field,
                              input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%0d required=%0d", nm, field, act, req);
    end
  endtask

  // Monitor: compares every pending expectation against the outputs,
  // sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk_i);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        compareField(e.name, "hrs",   hrs_o,          e.hrs);
        compareField(e.name, "min",   min_o,          e.min);
        compareField(e.name, "sec",   sec_o,          e.sec);
        compareField(e.name, "pm",    7'(pm_o),       7'(e.pm));
        compareField(e.name, "state", 7'(state_o),    7'(e.state));
        compareField(e.name, "blink", 7'(blink_o),    7'(e.blink));
      end
    end
  end

  // Queue an expectation and wait (bounded) for the monitor to consume it.
  task automatic checkOutput(input string nm, input logic [6:0] h,
                             input logic [6:0] m, input logic [6:0] s,
                             input logic p, input logic [1:0] st,
                             input logic [1:0] bl);
    exp_t e;
    #1;
    e.name = nm; e.hrs = h; e.min = m; e.sec = s;
    e.pm = p; e.state = st; e.blink = bl;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk_i);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.monitor actual=pending required=consumed", nm);
      exp_q.delete();
    end
  endtask

  // Drive one cycle of events (called on a falling edge), then idle a cycle
  // so button levels are seen low before the next press.
  task automatic applyStimulus(input logic tk, input logic md, input logic ic,
                               input logic ld, input logic [6:0] sh,
                               input logic [6:0] sm);
    tick_i = tk; mode_btn_i = md; inc_btn_i = ic; load_i = ld;
    sw_hrs_i = sh; sw_min_i = sm;
    @(negedge clk_i);
    tick_i = 1'b0; mode_btn_i = 1'b0; inc_btn_i = 1'b0; load_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic runTicks(input int n);
    tick_i = 1'b1;
    repeat (n) @(negedge clk_i);
    tick_i = 1'b0;
  endtask

  task automatic resetDut();
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    rst_n_i = 1'b0; tick_i = 1'b0; mode_btn_i = 1'b0; inc_btn_i = 1'b0;
    load_i = 1'b0; sw_hrs_i = 7'd0; sw_min_i = 7'd0;

    checkOutput("reset", 7'd12, 7'd0, 7'd0, 1'b0, 2'b00, 2'b00);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Free-running time and carries.
    runTicks(3599);
    checkOutput("ticks3599", 7'd12, 7'd59, 7'd59, 1'b0, 2'b00, 2'b00);
    runTicks(1);
    checkOutput("hour_carry", 7'd1, 7'd0, 7'd0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd11, 7'd59);
    checkOutput("load_11_59", 7'd11, 7'd59, 7'd0, 1'b0, 2'b00, 2'b00);
    runTicks(59);
    checkOutput("at_11_59_59", 7'd11, 7'd59, 7'd59, 1'b0, 2'b00, 2'b00);
    runTicks(1);
    checkOutput("pm_wrap", 7'd12, 7'd0, 7'd0, 1'b1, 2'b00, 2'b00);

    // Set flow from reset.
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    checkOutput("enter_set_hrs", 7'd12, 7'd0, 7'd0, 1'b0, 2'b01, 2'b10);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
    checkOutput("set_hrs_3", 7'd3, 7'd0, 7'd0, 1'b0, 2'b01, 2'b10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    checkOutput("tick_in_set_hrs", 7'd3, 7'd0, 7'd0, 1'b0, 2'b01, 2'b10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    checkOutput("enter_set_min", 7'd3, 7'd0, 7'd0, 1'b0, 2'b10, 2'b01);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
    checkOutput("set_min_tick_inc", 7'd3, 7'd5, 7'd0, 1'b0, 2'b10, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    checkOutput("back_to_run", 7'd3, 7'd5, 7'd0, 1'b0, 2'b00, 2'b00);

    // Loads: accepted from SET_MIN, then rejected variants in RUN.
    runTicks(7);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    checkOutput("set_min_hold_sec", 7'd3, 7'd5, 7'd7, 1'b0, 2'b10, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd12, 7'd30);
    checkOutput("load_12_30", 7'd12, 7'd30, 7'd0, 1'b0, 2'b00, 2'b00);
    runTicks(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd12, 7'd60);
    checkOutput("reject_min60", 7'd12, 7'd30, 7'd3, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 7'd10);
    checkOutput("reject_hrs0", 7'd12, 7'd30, 7'd3, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd13, 7'd10);
    checkOutput("reject_hrs13", 7'd12, 7'd30, 7'd3, 1'b0, 2'b00, 2'b00);

    // Same-cycle load, mode and tick: load wins, tick dropped.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 7'd5, 7'd7);
    checkOutput("load_priority", 7'd5, 7'd7, 7'd0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 7'd10);
    checkOutput("reject_in_set_hrs", 7'd5, 7'd7, 7'd0, 1'b0, 2'b01, 2'b10);

    // Hour wrap while editing toggles pm.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd11, 7'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
    checkOutput("set_hrs_wrap", 7'd12, 7'd0, 7'd0, 1'b1, 2'b01, 2'b10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    checkOutput("run_after_wrap", 7'd12, 7'd0, 7'd0, 1'b1, 2'b00, 2'b00);

    // Asynchronous reset mid-count with mode held through deassertion.
    runTicks(5);
    tick_i = 1'b1;
    mode_btn_i = 1'b1;
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    tick_i = 1'b0;
    checkOutput("async_reset", 7'd12, 7'd0, 7'd0, 1'b0, 2'b00, 2'b00);
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("held_mode_ignored", 7'd12, 7'd0, 7'd0, 1'b0, 2'b00, 2'b00);
    mode_btn_i = 1'b0;
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    checkOutput("fresh_press", 7'd12, 7'd0, 7'd0, 1'b0, 2'b01, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
